hex_scan_display: RTL

- Parametrised multi-digit, time-multiplexed hex seven-segment driver; the next generation after the single-digit hex-to-segment decoder.
- Decodes one 4-bit nibble per digit, adds per-digit decimal point, blanking and blinking, and scans DIGITS anodes round-robin.
- Input fields are double-buffered per frame so a display never shows a torn value.
- Sits between register/switch logic and the board's shared segment bus plus anode lines.

---
 rtl/hex_scan_display.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hex_scan_display.sv
// Time-multiplexed hex seven-segment driver for DIGITS digits with per-frame
// double-buffered inputs, decimal points, blanking and blinking.
module hex_scan_display #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int FLASH_BITS = 25,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] hex,
  input  logic [DIGITS-1:0]   point,
  input  logic [DIGITS-1:0]   blank,
  input  logic [DIGITS-1:0]   flash,
  output logic [7:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                frame
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]         SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]         SCAN_ONE  = CW'(1);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [IW-1:0]         IDX_ONE   = IW'(1);
  localparam logic [FLASH_BITS-1:0] FLASH_ONE = FLASH_BITS'(1);
  localparam logic [7:0]            SEG_POL   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0]     AN_POL    = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Active-high a..g pattern for one hex nibble.
  function automatic logic [6:0] font7(input logic [3:0] h);
    case (h)
      4'h0:    font7 = 7'h7E;
      4'h1:    font7 = 7'h30;
      4'h2:    font7 = 7'h6D;
      4'h3:    font7 = 7'h79;
      4'h4:    font7 = 7'h33;
      4'h5:    font7 = 7'h5B;
      4'h6:    font7 = 7'h5F;
      4'h7:    font7 = 7'h70;
      4'h8:    font7 = 7'h7F;
      4'h9:    font7 = 7'h7B;
      4'hA:    font7 = 7'h77;
      4'hB:    font7 = 7'h1F;
      4'hC:    font7 = 7'h4E;
      4'hD:    font7 = 7'h3D;
      4'hE:    font7 = 7'h4F;
      4'hF:    font7 = 7'h47;
      default: font7 = 7'h00;
    endcase
  endfunction

  logic [CW-1:0]         scan_cnt_r;
  logic [IW-1:0]         idx_r;
  logic [FLASH_BITS-1:0] flash_cnt_r;
  logic                  load_pending_r;
  logic [4*DIGITS-1:0]   hex_sh_r;
  logic [DIGITS-1:0]     point_sh_r;
  logic [DIGITS-1:0]     blank_sh_r;
  logic [DIGITS-1:0]     flash_sh_r;

  logic                  slot_end_s;
  logic                  load_s;
  logic                  dead_s;
  logic                  dark_s;
  logic [3:0]            digit_hex_s;
  logic                  digit_point_s;
  logic                  digit_blank_s;
  logic                  digit_flash_s;
  logic [7:0]            seg_raw_s;
  logic [DIGITS-1:0]     an_raw_s;

  // Select the current digit from the shadow copy and form active-high pin values.
  always_comb begin
    slot_end_s    = (scan_cnt_r == SCAN_LAST);
    load_s        = load_pending_r | (slot_end_s & (idx_r == IDX_LAST));
    dead_s        = (scan_cnt_r == {CW{1'b0}});
    digit_hex_s   = 4'h0;
    digit_point_s = 1'b0;
    digit_blank_s = 1'b0;
    digit_flash_s = 1'b0;
    an_raw_s      = {DIGITS{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      digit_hex_s   = digit_hex_s | ({4{idx_r == IW'(i)}} & hex_sh_r[4*i +: 4]);
      digit_point_s = digit_point_s | ((idx_r == IW'(i)) & point_sh_r[i]);
      digit_blank_s = digit_blank_s | ((idx_r == IW'(i)) & blank_sh_r[i]);
      digit_flash_s = digit_flash_s | ((idx_r == IW'(i)) & flash_sh_r[i]);
      an_raw_s[i]   = ~dead_s & (idx_r == IW'(i));
    end
    // Slot cycle 0 stays dark so the previous digit's segments never ghost onto the next anode.
    dark_s = dead_s | digit_blank_s | (digit_flash_s & flash_cnt_r[FLASH_BITS-1]);
    if (dark_s) begin
      seg_raw_s = 8'h00;
    end else begin
      seg_raw_s = {font7(digit_hex_s), digit_point_s};
    end
  end

  // Scan slot, digit index and blink counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_r  <= {CW{1'b0}};
      idx_r       <= {IW{1'b0}};
      flash_cnt_r <= {FLASH_BITS{1'b0}};
    end else begin
      flash_cnt_r <= flash_cnt_r + FLASH_ONE;
      if (slot_end_s) begin
        scan_cnt_r <= {CW{1'b0}};
        idx_r      <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IDX_ONE;
      end else begin
        scan_cnt_r <= scan_cnt_r + SCAN_ONE;
      end
    end
  end

  // Frame-synchronous shadow copy of the display inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_pending_r <= 1'b1;
      hex_sh_r       <= {(4*DIGITS){1'b0}};
      point_sh_r     <= {DIGITS{1'b0}};
      blank_sh_r     <= {DIGITS{1'b1}};
      flash_sh_r     <= {DIGITS{1'b0}};
    end else begin
      load_pending_r <= 1'b0;
      if (load_s) begin
        hex_sh_r   <= hex;
        point_sh_r <= point;
        blank_sh_r <= blank;
        flash_sh_r <= flash;
      end
    end
  end

  // Registered pins with board polarity applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg   <= SEG_POL;
      an    <= AN_POL;
      frame <= 1'b0;
    end else begin
      seg   <= seg_raw_s ^ SEG_POL;
      an    <= an_raw_s ^ AN_POL;
      frame <= load_s;
    end
  end

endmodule
